// File: rtl/dma_ram_rd_arb_if.sv
// Bundle of requester-side and RAM-side read buses.
// slave: arbiter view; master: requesters plus RAM.
interface dma_ram_rd_arb_if #(
  parameter int PORTS          = 2,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 128,
  parameter int SEG_ADDR_WIDTH = 8
);
  localparam int N  = PORTS * SEG_COUNT;
  localparam int AW = SEG_ADDR_WIDTH;
  localparam int DW = SEG_DATA_WIDTH;

  logic [N*AW-1:0]         s_rd_cmd_addr;
  logic [N-1:0]            s_rd_cmd_valid;
  logic [N-1:0]            s_rd_cmd_ready;
  logic [N*DW-1:0]         s_rd_resp_data;
  logic [N-1:0]            s_rd_resp_valid;
  logic [N-1:0]            s_rd_resp_ready;
  logic [SEG_COUNT*AW-1:0] m_rd_cmd_addr;
  logic [SEG_COUNT-1:0]    m_rd_cmd_valid;
  logic [SEG_COUNT-1:0]    m_rd_cmd_ready;
  logic [SEG_COUNT*DW-1:0] m_rd_resp_data;
  logic [SEG_COUNT-1:0]    m_rd_resp_valid;
  logic [SEG_COUNT-1:0]    m_rd_resp_ready;

  modport slave (
    input  s_rd_cmd_addr,
    input  s_rd_cmd_valid,
    output s_rd_cmd_ready,
    output s_rd_resp_data,
    output s_rd_resp_valid,
    input  s_rd_resp_ready,
    output m_rd_cmd_addr,
    output m_rd_cmd_valid,
    input  m_rd_cmd_ready,
    input  m_rd_resp_data,
    input  m_rd_resp_valid,
    output m_rd_resp_ready
  );

  modport master (
    output s_rd_cmd_addr,
    output s_rd_cmd_valid,
    input  s_rd_cmd_ready,
    input  s_rd_resp_data,
    input  s_rd_resp_valid,
    output s_rd_resp_ready,
    input  m_rd_cmd_addr,
    input  m_rd_cmd_valid,
    output m_rd_cmd_ready,
    output m_rd_resp_data,
    output m_rd_resp_valid,
    input  m_rd_resp_ready
  );
endinterface

// File: rtl/dma_ram_rd_arb.sv
// Round-robin read arbiter: PORTS requesters share SEG_COUNT RAM segments.
// Ports: clk, rst (sync, active-high), bus (dma_ram_rd_arb_if.slave).
// Flat bus lanes are indexed p*SEG_COUNT+n (port p, segment n).
// A per-segment tag FIFO remembers which port owns each in-order response.
module dma_ram_rd_arb #(
  parameter int PORTS          = 2,
  parameter int SEG_COUNT      = 2,
  parameter int SEG_DATA_WIDTH = 128,
  parameter int SEG_ADDR_WIDTH = 8,
  parameter int TAG_FIFO_DEPTH = 8
) (
  input logic             clk,
  input logic             rst,
  dma_ram_rd_arb_if.slave bus
);
  localparam int PW = $clog2(PORTS);
  localparam int FW = $clog2(TAG_FIFO_DEPTH);
  localparam int AW = SEG_ADDR_WIDTH;
  localparam int DW = SEG_DATA_WIDTH;

  localparam logic [PW:0]   NP   = (PW+1)'(PORTS);
  localparam logic [PW-1:0] LAST = PW'(PORTS-1);
  localparam logic [FW:0]   FULL = (FW+1)'(TAG_FIFO_DEPTH);

  for (genvar n = 0; n < SEG_COUNT; n++) begin : g_seg
    logic [PORTS-1:0] req;
    logic [PORTS-1:0] rsp_rdy;
    logic [PW-1:0]    win;
    logic [PW:0]      idx;
    logic             any;
    logic [AW-1:0]    addr;
    logic [PW-1:0]    head;
    logic             full;
    logic             empty;
    logic             cmd_valid;
    logic             resp_ready;
    logic             push;
    logic             pop;

    logic [PW-1:0] rr_q, rr_d;
    logic [FW-1:0] wr_q, wr_d;
    logic [FW-1:0] rd_q, rd_d;
    logic [FW:0]   cnt_q, cnt_d;
    logic [PW-1:0] tag_q [TAG_FIFO_DEPTH];
    logic [PW-1:0] tag_d [TAG_FIFO_DEPTH];

    for (genvar p = 0; p < PORTS; p++) begin : g_port
      localparam int L = p * SEG_COUNT + n;
      assign req[p] = bus.s_rd_cmd_valid[L];
      assign rsp_rdy[p] = bus.s_rd_resp_ready[L];
      assign bus.s_rd_cmd_ready[L] =
        cmd_valid && bus.m_rd_cmd_ready[n]
        && win == PW'(p);
      assign bus.s_rd_resp_valid[L] =
        !rst && !empty && bus.m_rd_resp_valid[n]
        && head == PW'(p);
      // Data is broadcast; only the valid lane matters.
      assign bus.s_rd_resp_data[L*DW +: DW] =
        bus.m_rd_resp_data[n*DW +: DW];
    end

    assign full  = cnt_q == FULL;
    assign empty = cnt_q == '0;
    assign head  = tag_q[rd_q];

    // First requester at or after rr_q wins.
    always_comb begin
      win  = '0;
      any  = 1'b0;
      idx  = '0;
      addr = '0;
      for (int i = 0; i < PORTS; i++) begin
        idx = {1'b0, rr_q} + (PW+1)'(i);
        if (idx >= NP) idx = idx - NP;
        if (!any && req[idx[PW-1:0]]) begin
          any = 1'b1;
          win = idx[PW-1:0];
        end
      end
      for (int p = 0; p < PORTS; p++) begin
        if (win == PW'(p))
          addr = bus.s_rd_cmd_addr[(p*SEG_COUNT+n)*AW +: AW];
      end
    end

    // Full blocks issue even when a pop lands this cycle.
    assign cmd_valid  = !rst && any && !full;
    assign resp_ready = !rst && !empty && rsp_rdy[head];
    assign push = cmd_valid && bus.m_rd_cmd_ready[n];
    assign pop  = resp_ready && bus.m_rd_resp_valid[n];

    assign bus.m_rd_cmd_valid[n]         = cmd_valid;
    assign bus.m_rd_cmd_addr[n*AW +: AW] = addr;
    assign bus.m_rd_resp_ready[n]        = resp_ready;

    always_comb begin
      rr_d  = rr_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      tag_d = tag_q;
      if (push) begin
        rr_d = (win == LAST) ? '0 : win + 1'b1;
        tag_d[wr_q] = win;
        wr_d = wr_q + 1'b1;
      end
      if (pop) rd_d = rd_q + 1'b1;
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        rr_q  <= '0;
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        tag_q <= '{default: '0};
      end else begin
        rr_q  <= rr_d;
        wr_q  <= wr_d;
        rd_q  <= rd_d;
        cnt_q <= cnt_d;
        tag_q <= tag_d;
      end
    end
  end
endmodule

// File: tb/tb_dma_ram_rd_arb.sv
// Directed bench for dma_ram_rd_arb.
// Two ports, two segments, tag FIFO depth 8.
module tb_dma_ram_rd_arb;
  localparam int P  = 2;
  localparam int S  = 2;
  localparam int DW = 128;
  localparam int AW = 8;
  localparam int D  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dma_ram_rd_arb_if #(
    .PORTS(P), .SEG_COUNT(S),
    .SEG_DATA_WIDTH(DW), .SEG_ADDR_WIDTH(AW)
  ) bus ();

  dma_ram_rd_arb #(
    .PORTS(P), .SEG_COUNT(S),
    .SEG_DATA_WIDTH(DW), .SEG_ADDR_WIDTH(AW),
    .TAG_FIFO_DEPTH(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.s_rd_cmd_addr   = '0;
    bus.s_rd_cmd_valid  = '0;
    bus.s_rd_resp_ready = '0;
    bus.m_rd_cmd_ready  = '0;
    bus.m_rd_resp_data  = '0;
    bus.m_rd_resp_valid = '0;
  endtask

  task automatic set_cmd(input int p, input int s,
                         input logic v, input logic [7:0] a);
    bus.s_rd_cmd_valid[p*S+s] = v;
    bus.s_rd_cmd_addr[(p*S+s)*AW +: AW] = a;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.s_rd_cmd_valid  = '1;
    bus.s_rd_resp_ready = '1;
    bus.m_rd_cmd_ready  = '1;
    bus.m_rd_resp_valid = '1;
    tick();
    n_cmp++;
    if (bus.m_rd_cmd_valid !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_mcv got %b want 00", bus.m_rd_cmd_valid);
    end
    n_cmp++;
    if (bus.s_rd_cmd_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_scr got %b want 0000", bus.s_rd_cmd_ready);
    end
    n_cmp++;
    if (bus.m_rd_resp_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL rst_mrr got %b want 00", bus.m_rd_resp_ready);
    end
    n_cmp++;
    if (bus.s_rd_resp_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL rst_srv got %b want 0000", bus.s_rd_resp_valid);
    end
    do_reset();
  endtask

  task automatic test_single;
    do_reset();
    bus.m_rd_cmd_ready = 2'b11;
    set_cmd(1, 0, 1'b1, 8'h12);
    #1;
    n_cmp++;
    if (bus.m_rd_cmd_addr[7:0] !== 8'h12) begin
      n_bad++;
      $display("FAIL single_addr got %h want 12", bus.m_rd_cmd_addr[7:0]);
    end
    n_cmp++;
    if (bus.m_rd_cmd_valid !== 2'b01) begin
      n_bad++;
      $display("FAIL single_mcv got %b want 01", bus.m_rd_cmd_valid);
    end
    n_cmp++;
    if (bus.s_rd_cmd_ready !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_scr got %b want 0100", bus.s_rd_cmd_ready);
    end
    tick();
    bus.m_rd_cmd_ready = 2'b00;
    set_cmd(0, 0, 1'b1, 8'h20);
    set_cmd(1, 0, 1'b1, 8'h21);
    #1;
    n_cmp++;
    if (bus.m_rd_cmd_addr[7:0] !== 8'h20) begin
      n_bad++;
      $display("FAIL single_rr0 got %h want 20", bus.m_rd_cmd_addr[7:0]);
    end
    set_cmd(0, 0, 1'b0, 8'h00);
    set_cmd(1, 0, 1'b0, 8'h00);
    bus.m_rd_resp_valid = 2'b01;
    bus.m_rd_resp_data[DW-1:0] = 128'hABCD;
    bus.s_rd_resp_ready = 4'hF;
    #1;
    n_cmp++;
    if (bus.s_rd_resp_valid !== 4'b0100) begin
      n_bad++;
      $display("FAIL single_srv got %b want 0100", bus.s_rd_resp_valid);
    end
    n_cmp++;
    if (bus.s_rd_resp_data[2*DW +: DW] !== 128'hABCD) begin
      n_bad++;
      $display("FAIL single_data got %h want abcd",
               bus.s_rd_resp_data[2*DW +: DW]);
    end
    n_cmp++;
    if (bus.m_rd_resp_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL single_mrr got %b want 01", bus.m_rd_resp_ready);
    end
    tick();
    n_cmp++;
    if (bus.m_rd_resp_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL empty_mrr got %b want 00", bus.m_rd_resp_ready);
    end
    n_cmp++;
    if (bus.s_rd_resp_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL empty_srv got %b want 0000", bus.s_rd_resp_valid);
    end
    idle();
  endtask

  task automatic test_alternate;
    logic [3:0] e;
    do_reset();
    bus.m_rd_cmd_ready = 2'b01;
    set_cmd(0, 0, 1'b1, 8'h30);
    set_cmd(1, 0, 1'b1, 8'h31);
    for (int k = 0; k < 4; k++) begin
      #1;
      e = 4'(1 << ((k % 2) * S));
      n_cmp++;
      if (bus.s_rd_cmd_ready !== e) begin
        n_bad++;
        $display("FAIL alt_grant%0d got %b want %b",
                 k, bus.s_rd_cmd_ready, e);
      end
      n_cmp++;
      if (bus.m_rd_cmd_addr[7:0] !== 8'(8'h30 + k % 2)) begin
        n_bad++;
        $display("FAIL alt_addr%0d got %h", k, bus.m_rd_cmd_addr[7:0]);
      end
      tick();
    end
    set_cmd(0, 0, 1'b0, 8'h00);
    set_cmd(1, 0, 1'b0, 8'h00);
    bus.m_rd_resp_valid = 2'b01;
    bus.s_rd_resp_ready = 4'hF;
    for (int k = 0; k < 4; k++) begin
      bus.m_rd_resp_data[DW-1:0] = 128'(k + 100);
      #1;
      e = 4'(1 << ((k % 2) * S));
      n_cmp++;
      if (bus.s_rd_resp_valid !== e) begin
        n_bad++;
        $display("FAIL alt_resp%0d got %b want %b",
                 k, bus.s_rd_resp_valid, e);
      end
      n_cmp++;
      if (bus.s_rd_resp_data[((k % 2) * S) * DW +: DW]
          !== 128'(k + 100)) begin
        n_bad++;
        $display("FAIL alt_data%0d got %h want %0d", k,
                 bus.s_rd_resp_data[((k % 2) * S) * DW +: DW], k + 100);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_full;
    do_reset();
    bus.m_rd_cmd_ready = 2'b01;
    set_cmd(0, 0, 1'b1, 8'h40);
    for (int k = 0; k < D; k++) begin
      #1;
      n_cmp++;
      if (bus.s_rd_cmd_ready[0] !== 1'b1) begin
        n_bad++;
        $display("FAIL full_acc%0d got %b want 1",
                 k, bus.s_rd_cmd_ready[0]);
      end
      tick();
    end
    n_cmp++;
    if (bus.s_rd_cmd_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL full_scr got %b want 0000", bus.s_rd_cmd_ready);
    end
    n_cmp++;
    if (bus.m_rd_cmd_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL full_mcv got %b want 0", bus.m_rd_cmd_valid[0]);
    end
    bus.m_rd_resp_valid = 2'b01;
    bus.s_rd_resp_ready = 4'hF;
    #1;
    n_cmp++;
    if (bus.s_rd_cmd_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL full_pop_scr got %b want 0000", bus.s_rd_cmd_ready);
    end
    n_cmp++;
    if (bus.m_rd_resp_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL full_pop_mrr got %b want 01", bus.m_rd_resp_ready);
    end
    tick();
    bus.m_rd_resp_valid = 2'b00;
    #1;
    n_cmp++;
    if (bus.s_rd_cmd_ready !== 4'b0001) begin
      n_bad++;
      $display("FAIL ninth_scr got %b want 0001", bus.s_rd_cmd_ready);
    end
    tick();
    set_cmd(0, 0, 1'b0, 8'h00);
    bus.m_rd_resp_valid = 2'b01;
    for (int k = 0; k < D; k++) begin
      #1;
      n_cmp++;
      if (bus.s_rd_resp_valid !== 4'b0001) begin
        n_bad++;
        $display("FAIL drain%0d got %b want 0001",
                 k, bus.s_rd_resp_valid);
      end
      tick();
    end
    n_cmp++;
    if (bus.m_rd_resp_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL drained_mrr got %b want 00", bus.m_rd_resp_ready);
    end
    idle();
  endtask

  task automatic test_blocked;
    do_reset();
    bus.m_rd_cmd_ready = 2'b01;
    set_cmd(0, 0, 1'b1, 8'h01);
    tick();
    set_cmd(0, 0, 1'b0, 8'h00);
    set_cmd(1, 0, 1'b1, 8'h02);
    tick();
    set_cmd(1, 0, 1'b0, 8'h00);
    bus.m_rd_resp_valid = 2'b01;
    bus.s_rd_resp_ready = 4'b0100;
    for (int k = 0; k < 2; k++) begin
      #1;
      n_cmp++;
      if (bus.m_rd_resp_ready !== 2'b00) begin
        n_bad++;
        $display("FAIL blk_mrr%0d got %b want 00",
                 k, bus.m_rd_resp_ready);
      end
      n_cmp++;
      if (bus.s_rd_resp_valid !== 4'b0001) begin
        n_bad++;
        $display("FAIL blk_srv%0d got %b want 0001",
                 k, bus.s_rd_resp_valid);
      end
      tick();
    end
    bus.s_rd_resp_ready = 4'hF;
    #1;
    n_cmp++;
    if (bus.m_rd_resp_ready !== 2'b01) begin
      n_bad++;
      $display("FAIL unblk_mrr got %b want 01", bus.m_rd_resp_ready);
    end
    tick();
    n_cmp++;
    if (bus.s_rd_resp_valid !== 4'b0100) begin
      n_bad++;
      $display("FAIL unblk_srv got %b want 0100", bus.s_rd_resp_valid);
    end
    tick();
    idle();
  endtask

  task automatic test_two_seg;
    do_reset();
    bus.m_rd_cmd_ready = 2'b11;
    set_cmd(0, 0, 1'b1, 8'h05);
    set_cmd(1, 1, 1'b1, 8'h3A);
    #1;
    n_cmp++;
    if (bus.m_rd_cmd_valid !== 2'b11) begin
      n_bad++;
      $display("FAIL seg_mcv got %b want 11", bus.m_rd_cmd_valid);
    end
    n_cmp++;
    if (bus.m_rd_cmd_addr !== 16'h3A05) begin
      n_bad++;
      $display("FAIL seg_addr got %h want 3a05", bus.m_rd_cmd_addr);
    end
    n_cmp++;
    if (bus.s_rd_cmd_ready !== 4'b1001) begin
      n_bad++;
      $display("FAIL seg_scr got %b want 1001", bus.s_rd_cmd_ready);
    end
    tick();
    set_cmd(0, 0, 1'b1, 8'h50);
    set_cmd(1, 0, 1'b1, 8'h51);
    set_cmd(0, 1, 1'b1, 8'h60);
    set_cmd(1, 1, 1'b1, 8'h61);
    #1;
    n_cmp++;
    if (bus.s_rd_cmd_ready !== 4'b0110) begin
      n_bad++;
      $display("FAIL seg_rr_scr got %b want 0110", bus.s_rd_cmd_ready);
    end
    n_cmp++;
    if (bus.m_rd_cmd_addr !== 16'h6051) begin
      n_bad++;
      $display("FAIL seg_rr_addr got %h want 6051", bus.m_rd_cmd_addr);
    end
    tick();
    bus.s_rd_cmd_valid = '0;
    bus.m_rd_resp_valid = 2'b10;
    bus.m_rd_resp_data[DW +: DW] = 128'h77;
    bus.s_rd_resp_ready = 4'hF;
    #1;
    n_cmp++;
    if (bus.s_rd_resp_valid !== 4'b1000) begin
      n_bad++;
      $display("FAIL seg1_srv got %b want 1000", bus.s_rd_resp_valid);
    end
    n_cmp++;
    if (bus.s_rd_resp_data[3*DW +: DW] !== 128'h77) begin
      n_bad++;
      $display("FAIL seg1_data got %h want 77",
               bus.s_rd_resp_data[3*DW +: DW]);
    end
    tick();
    idle();
  endtask

  task automatic test_reset_mid;
    do_reset();
    bus.m_rd_cmd_ready = 2'b01;
    set_cmd(0, 0, 1'b1, 8'h01);
    tick();
    tick();
    tick();
    rst = 1'b1;
    bus.s_rd_cmd_valid  = '1;
    bus.s_rd_resp_ready = '1;
    bus.m_rd_cmd_ready  = 2'b11;
    bus.m_rd_resp_valid = 2'b11;
    tick();
    n_cmp++;
    if (bus.m_rd_cmd_valid !== 2'b00
        || bus.s_rd_cmd_ready !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_cmd got %b/%b want 00/0000",
               bus.m_rd_cmd_valid, bus.s_rd_cmd_ready);
    end
    n_cmp++;
    if (bus.m_rd_resp_ready !== 2'b00
        || bus.s_rd_resp_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_resp got %b/%b want 00/0000",
               bus.m_rd_resp_ready, bus.s_rd_resp_valid);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.m_rd_resp_ready !== 2'b00) begin
      n_bad++;
      $display("FAIL mid_empty got %b want 00", bus.m_rd_resp_ready);
    end
    n_cmp++;
    if (bus.s_rd_resp_valid !== 4'b0000) begin
      n_bad++;
      $display("FAIL mid_srv got %b want 0000", bus.s_rd_resp_valid);
    end
    n_cmp++;
    if (bus.s_rd_cmd_ready !== 4'b0011) begin
      n_bad++;
      $display("FAIL mid_rr got %b want 0011", bus.s_rd_cmd_ready);
    end
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_single();
    test_alternate();
    test_full();
    test_blocked();
    test_two_seg();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/dma_ram_rd_arb.md
DMA_RAM_RD_ARB -- requirements
Module: dma_ram_rd_arb

Interface
REQ-001 SHALL have parameter PORTS, default 2, number of read requesters (2..8).
REQ-002 SHALL have parameter SEG_COUNT, default 2, RAM segments per port.
REQ-003 SHALL have parameter SEG_DATA_WIDTH, default 128, segment data width.
REQ-004 SHALL have parameter SEG_ADDR_WIDTH, default 8, segment address width.
REQ-005 SHALL have parameter TAG_FIFO_DEPTH, default 8, max outstanding reads per segment (power of 2).
REQ-006 SHALL have clk, input, 1, clock; all logic on the rising edge.
REQ-007 SHALL have rst, input, 1, reset: synchronous, active-high.
REQ-008 SHALL have s_rd_cmd_addr, input, PORTS*SEG_COUNT*SEG_ADDR_WIDTH, per-port per-segment read address.
REQ-009 SHALL have s_rd_cmd_valid, input, PORTS*SEG_COUNT, per-port per-segment command valid.
REQ-010 SHALL have s_rd_cmd_ready, output, PORTS*SEG_COUNT, command accepted.
REQ-011 SHALL have s_rd_resp_data, output, PORTS*SEG_COUNT*SEG_DATA_WIDTH, routed read data.
REQ-012 SHALL have s_rd_resp_valid, output, PORTS*SEG_COUNT, routed response valid.
REQ-013 SHALL have s_rd_resp_ready, input, PORTS*SEG_COUNT, requester response ready.
REQ-014 SHALL have m_rd_cmd_addr, output, SEG_COUNT*SEG_ADDR_WIDTH, address to RAM read port.
REQ-015 SHALL have m_rd_cmd_valid, output, SEG_COUNT, command valid to RAM.
REQ-016 SHALL have m_rd_cmd_ready, input, SEG_COUNT, RAM command ready.
REQ-017 SHALL have m_rd_resp_data, input, SEG_COUNT*SEG_DATA_WIDTH, RAM read data.
REQ-018 SHALL have m_rd_resp_valid, input, SEG_COUNT, RAM response valid.
REQ-019 SHALL have m_rd_resp_ready, output, SEG_COUNT, response ready to RAM.

Function
REQ-020 Each segment SHALL be arbitrated independently; segment n of port p only competes with segment n of other ports.
REQ-021 Per segment, round-robin: priority starts at pointer rr[n]; first valid port at or after rr[n] (modulo PORTS) wins.
REQ-022 Command path SHALL be combinational: m_rd_cmd_valid[n] = any valid AND tag FIFO not full; m_rd_cmd_addr[n] = winner's address.
REQ-023 s_rd_cmd_ready SHALL be asserted only for the winner, equal to m_rd_cmd_ready[n] AND tag FIFO not full; 0 for losers.
REQ-024 On handshake (m_rd_cmd_valid & m_rd_cmd_ready), winner index SHALL be pushed into tag FIFO n and rr[n] <= winner+1 modulo PORTS; no handshake -> rr[n] unchanged.
REQ-025 Tag FIFO full (TAG_FIFO_DEPTH entries): m_rd_cmd_valid[n] and all s_rd_cmd_ready for segment n SHALL be 0, even if a pop occurs same cycle.
REQ-026 Responses SHALL return in RAM order; head tag t routes m_rd_resp_data[n] and valid to port t segment n; other ports' valid 0.
REQ-027 m_rd_resp_ready[n] = s_rd_resp_ready of port t segment n when FIFO non-empty; 0 when empty.
REQ-028 Tag pop on m_rd_resp_valid & m_rd_resp_ready; simultaneous push and pop SHALL keep count unchanged and preserve order.
REQ-029 Response with empty FIFO (protocol violation) SHALL be stalled (ready 0), never routed.
REQ-030 s_rd_resp_data for non-addressed ports SHALL be don't-care; may be broadcast.
REQ-031 Pointer and count arithmetic SHALL wrap modulo depth/PORTS without overflow into adjacent fields.

Reset
REQ-032 While rst=1: rr[n]=0, tag FIFOs empty, m_rd_cmd_valid=0, s_rd_cmd_ready=0, m_rd_resp_ready=0, s_rd_resp_valid=0.
REQ-033 Reset mid-operation SHALL discard outstanding tags; the RAM is reset by the same rst so no stale responses arrive.

Verification
REQ-034 Ports 0,1 seg0 valid continuously, RAM ready=1 -> grants alternate 0,1,0,1; responses routed to matching port in order.
REQ-035 Only port 1 valid, addr 0x12 -> m_rd_cmd_addr=0x12 same cycle, rr=0 afterward; response to port 1 only.
REQ-036 RAM never returns responses, 9 requests -> 8 accepted, ninth held with s_rd_cmd_ready=0 until one pop.
REQ-037 Port 0 s_rd_resp_ready=0 at head tag 0 -> m_rd_resp_ready=0, later port 1 response blocked behind it.
REQ-038 Seg0 and seg1 requested by different ports same cycle -> both granted in one cycle, independent pointers.
REQ-039 rst asserted with 3 outstanding -> next cycle all valids/readies 0, FIFOs empty, rr=0.
